// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI configuration front end.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_W      = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DATA_W     = 8;

  // Frame bit that carries the R/W flag, and the value meaning "write".
  localparam int unsigned RW_POS   = 0;
  localparam logic        RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register, MSB shifted out first.
module spi_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {q[WIDTH-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 16-bit frames into register-file writes
// and serialises register-file read data onto sdo. Runs on spi_clk only.
module spi_slave_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CMD_W  = 8
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sdi,
  input  logic [DATA_W-1:0] read_data,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [DATA_W-1:0] spi_if_dout,
  output logic [ADDR_W-1:0] spi_if_index,
  output logic              spi_if_wr_en,
  output logic              frame_err
);

  import spi_pkg::*;

  localparam logic [3:0] LastCmdBit = 4'(CMD_W - 1);
  localparam logic [3:0] FirstData  = 4'(CMD_W);
  localparam logic [3:0] LastBit    = 4'(FRAME_BITS - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;
  logic              oe_q, oe_d;

  logic              cap_shift;
  logic              tx_load, tx_shift, tx_clear;
  logic [DATA_W-1:0] cap_q, tx_q;

  // Capture register shifts every frame bit, so the command sits in its low
  // bits just before the edge sampling bit 7.
  spi_shift_reg #(
    .WIDTH (DATA_W)
  ) u_capture (
    .clk      (spi_clk),
    .rst      (rst),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .shift    (cap_shift),
    .sin      (sdi),
    .q        (cap_q)
  );

  spi_shift_reg #(
    .WIDTH (DATA_W)
  ) u_transmit (
    .clk      (spi_clk),
    .rst      (rst),
    .clear    (tx_clear),
    .load     (tx_load),
    .load_val (read_data),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    index_d   = index_q;
    dout_d    = dout_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    oe_d      = oe_q;
    cap_shift = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    tx_clear  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Also the frame-boundary edge after bit 15: drop the read driver.
        oe_d     = 1'b0;
        tx_clear = 1'b1;
        if (!cs_n) begin
          cap_shift = 1'b1;
          cnt_d     = 4'd1;
          state_d   = StCmd;
        end
      end

      StCmd: begin
        if (cs_n) begin
          state_d  = StIdle;
          cnt_d    = '0;
          oe_d     = 1'b0;
          tx_clear = 1'b1;
          err_d    = 1'b1;
        end else begin
          cap_shift = 1'b1;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == LastCmdBit) begin
            index_d = cap_q[CMD_W-3 -: ADDR_W];
            rw_d    = cap_q[CMD_W-2-RW_POS];
            state_d = StData;
          end
        end
      end

      StData: begin
        if (cs_n) begin
          state_d  = StIdle;
          cnt_d    = '0;
          oe_d     = 1'b0;
          tx_clear = 1'b1;
          err_d    = 1'b1;
        end else begin
          cap_shift = 1'b1;
          if (cnt_q == FirstData && rw_q != RW_WRITE) begin
            tx_load = 1'b1;
            oe_d    = 1'b1;
          end else begin
            tx_shift = 1'b1;
          end
          if (cnt_q == LastBit) begin
            cnt_d   = '0;
            state_d = StIdle;
            if (rw_q == RW_WRITE) begin
              dout_d  = {cap_q[DATA_W-2:0], sdi};
              wr_en_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      index_q <= '0;
      dout_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      index_q <= index_d;
      dout_q  <= dout_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{cap_q[DATA_W-1], tx_q[DATA_W-2:0]};

  assign sdo          = oe_q & tx_q[DATA_W-1];
  assign sdo_oe       = oe_q;
  assign spi_if_dout  = dout_q;
  assign spi_if_index = index_q;
  assign spi_if_wr_en = wr_en_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if with a frame-level register file model.
module tb_spi_slave_if;

  logic       spi_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic [7:0] read_data;
  logic       sdo, sdo_oe, spi_if_wr_en, frame_err;
  logic [7:0] spi_if_dout;
  logic [2:0] spi_if_index;

  always #5 spi_clk = ~spi_clk;

  spi_slave_if dut (
    .spi_clk      (spi_clk),
    .rst          (rst),
    .cs_n         (cs_n),
    .sdi          (sdi),
    .read_data    (read_data),
    .sdo          (sdo),
    .sdo_oe       (sdo_oe),
    .spi_if_dout  (spi_if_dout),
    .spi_if_index (spi_if_index),
    .spi_if_wr_en (spi_if_wr_en),
    .frame_err    (frame_err)
  );

  // Environment register file, written only by the DUT's write port.
  logic [7:0] regs [8];
  logic       env_init = 1'b1;
  assign read_data = regs[spi_if_index];
  always @(posedge spi_clk) begin
    if (env_init) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'(i * 37 + 5);
    end else if (spi_if_wr_en) begin
      regs[spi_if_index] <= spi_if_dout;
    end
  end

  // Reference model: register contents implied by the frames sent so far.
  logic [7:0] mregs [8];
  logic [7:0] exp_dout;

  int n_checks = 0;
  int n_err = 0;

  logic       obs_sdo [40];
  logic       obs_oe [40];
  logic       obs_wr [40];
  logic       obs_err [40];
  logic [2:0] obs_idx [40];
  logic [7:0] obs_dout [40];

  task automatic tick(input logic cs, input logic d, input logic r, input int k);
    @(negedge spi_clk);
    cs_n = cs;
    sdi  = d;
    rst  = r;
    @(posedge spi_clk);
    #1;
    if (k < 40) begin
      obs_sdo[k]  = sdo;
      obs_oe[k]   = sdo_oe;
      obs_wr[k]   = spi_if_wr_en;
      obs_err[k]  = frame_err;
      obs_idx[k]  = spi_if_index;
      obs_dout[k] = spi_if_dout;
    end
  endtask

  // Bit k of the burst is v[31-k]; tail edges follow with cs_n high.
  task automatic send(input logic [31:0] v, input int nbits, input int tail);
    for (int k = 0; k < nbits + tail; k++) begin
      tick((k < nbits) ? 1'b0 : 1'b1, (k < nbits) ? v[31-k] : 1'b0, 1'b0, k);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b1, 0);
    tick(1'b1, 1'b0, 1'b1, 0);
    env_init = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'(i * 37 + 5);
    exp_dout = 8'h00;
    n_checks++;
    if ({sdo, sdo_oe, spi_if_wr_en, frame_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_bits got=%b exp=0000", {sdo, sdo_oe, spi_if_wr_en, frame_err});
    end
    n_checks++;
    if (spi_if_dout !== 8'h00 || spi_if_index !== 3'd0) begin
      n_err++;
      $display("FAIL reset_bus got dout=%h idx=%0d exp 0/0", spi_if_dout, spi_if_index);
    end
    tick(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_write();
    logic [15:0] f;
    f = 16'b1_001_0000_0010_1101;
    send({f, 16'h0}, 16, 2);
    mregs[1] = 8'h2D;
    exp_dout = 8'h2D;
    for (int k = 0; k < 18; k++) begin
      n_checks++;
      if (obs_wr[k] !== (k == 15) || obs_oe[k] !== 1'b0 || obs_err[k] !== 1'b0) begin
        n_err++;
        $display("FAIL write_strobe k=%0d got wr=%b oe=%b err=%b exp wr=%b oe=0 err=0",
                 k, obs_wr[k], obs_oe[k], obs_err[k], k == 15);
      end
    end
    n_checks++;
    if (obs_idx[15] !== 3'd1 || obs_dout[15] !== 8'h2D) begin
      n_err++;
      $display("FAIL write_data got idx=%0d dout=%h exp idx=1 dout=2d", obs_idx[15], obs_dout[15]);
    end
  endtask

  task automatic test_read();
    logic [15:0] f;
    send({16'b1_000_0000_1010_1000, 16'h0}, 16, 0);
    mregs[0] = 8'hA8;
    exp_dout = 8'hA8;
    f = {1'b0, 3'd0, 4'h0, 8'(($urandom))};
    send({f, 16'h0}, 16, 1);
    for (int k = 0; k < 17; k++) begin
      logic exp_oe, exp_sdo;
      exp_oe  = (k >= 8 && k <= 15);
      exp_sdo = exp_oe ? mregs[0][15-k] : 1'b0;
      n_checks++;
      if (obs_sdo[k] !== exp_sdo || obs_oe[k] !== exp_oe || obs_wr[k] !== 1'b0) begin
        n_err++;
        $display("FAIL read_a8 k=%0d got sdo=%b oe=%b wr=%b exp sdo=%b oe=%b wr=0",
                 k, obs_sdo[k], obs_oe[k], obs_wr[k], exp_sdo, exp_oe);
      end
    end
  endtask

  task automatic test_back_to_back();
    send({16'h80F8, 16'h903F}, 32, 2);
    mregs[0] = 8'hF8;
    mregs[1] = 8'h3F;
    exp_dout = 8'h3F;
    for (int k = 0; k < 34; k++) begin
      n_checks++;
      if (obs_wr[k] !== (k == 15 || k == 31)) begin
        n_err++;
        $display("FAIL b2b_strobe k=%0d got=%b exp=%b", k, obs_wr[k], k == 15 || k == 31);
      end
    end
    n_checks++;
    if (obs_idx[15] !== 3'd0 || obs_dout[15] !== 8'hF8) begin
      n_err++;
      $display("FAIL b2b_first got idx=%0d dout=%h exp 0/f8", obs_idx[15], obs_dout[15]);
    end
    n_checks++;
    if (obs_idx[22] !== 3'd0 || obs_idx[23] !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_index_hold got k22=%0d k23=%0d exp 0/1", obs_idx[22], obs_idx[23]);
    end
    n_checks++;
    if (obs_idx[31] !== 3'd1 || obs_dout[31] !== 8'h3F) begin
      n_err++;
      $display("FAIL b2b_second got idx=%0d dout=%h exp 1/3f", obs_idx[31], obs_dout[31]);
    end
  endtask

  task automatic test_abort();
    logic [15:0] f;
    f = {1'b1, 3'd2, 4'hA, 8'(~mregs[2])};
    send({f, 16'h0}, 10, 2);
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (obs_err[k] !== (k == 10) || obs_wr[k] !== 1'b0 || obs_dout[k] !== exp_dout) begin
        n_err++;
        $display("FAIL abort k=%0d got err=%b wr=%b dout=%h exp err=%b wr=0 dout=%h",
                 k, obs_err[k], obs_wr[k], obs_dout[k], k == 10, exp_dout);
      end
    end
    n_checks++;
    if (obs_idx[11] !== 3'd2 || obs_oe[11] !== 1'b0 || obs_sdo[11] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state got idx=%0d oe=%b sdo=%b exp 2/0/0",
               obs_idx[11], obs_oe[11], obs_sdo[11]);
    end
    send({16'h2000, 16'h0}, 16, 1);
    for (int k = 8; k < 16; k++) begin
      n_checks++;
      if (obs_sdo[k] !== mregs[2][15-k] || obs_oe[k] !== 1'b1) begin
        n_err++;
        $display("FAIL abort_readback k=%0d got sdo=%b oe=%b exp sdo=%b oe=1",
                 k, obs_sdo[k], obs_oe[k], mregs[2][15-k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    logic [7:0]  d;
    f = {1'b1, 3'd3, 4'h0, 8'(~mregs[3])};
    for (int k = 0; k < 12; k++) tick(1'b0, f[15-k], 1'b0, k);
    tick(1'b0, f[3], 1'b1, 12);
    tick(1'b1, 1'b0, 1'b0, 13);
    tick(1'b1, 1'b0, 1'b0, 14);
    exp_dout = 8'h00;
    n_checks++;
    if ({obs_sdo[12], obs_oe[12], obs_wr[12], obs_err[12]} !== 4'b0000 ||
        obs_dout[12] !== 8'h00 || obs_idx[12] !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid got sdo=%b oe=%b wr=%b err=%b dout=%h idx=%0d exp all 0",
               obs_sdo[12], obs_oe[12], obs_wr[12], obs_err[12], obs_dout[12], obs_idx[12]);
    end
    n_checks++;
    if (obs_wr[13] !== 1'b0 || obs_wr[14] !== 1'b0 || obs_err[13] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after got wr=%b%b err=%b exp 00/0", obs_wr[13], obs_wr[14], obs_err[13]);
    end
    d = 8'($urandom);
    send({1'b1, 3'd6, 4'h0, d, 16'h0}, 16, 2);
    mregs[6] = d;
    exp_dout = d;
    n_checks++;
    if (obs_wr[15] !== 1'b1 || obs_wr[16] !== 1'b0 || obs_idx[15] !== 3'd6 ||
        obs_dout[15] !== d) begin
      n_err++;
      $display("FAIL rst_recover got wr=%b%b idx=%0d dout=%h exp 10/6/%h",
               obs_wr[15], obs_wr[16], obs_idx[15], obs_dout[15], d);
    end
  endtask

  task automatic test_read_reserved();
    send({16'b1_101_0000_0000_1100, 16'h0}, 16, 1);
    mregs[5] = 8'h0C;
    exp_dout = 8'h0C;
    for (int pass = 0; pass < 2; pass++) begin
      logic [15:0] f;
      f = {1'b0, 3'd5, (pass == 0) ? 4'h0 : 4'hF, 8'($urandom)};
      send({f, 16'h0}, 16, 1);
      for (int k = 8; k < 16; k++) begin
        n_checks++;
        if (obs_sdo[k] !== mregs[5][15-k] || obs_oe[k] !== 1'b1 || obs_wr[k] !== 1'b0) begin
          n_err++;
          $display("FAIL read_res%0d k=%0d got sdo=%b oe=%b wr=%b exp sdo=%b oe=1 wr=0",
                   pass, k, obs_sdo[k], obs_oe[k], obs_wr[k], mregs[5][15-k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic        rw;
      logic [2:0]  idx;
      logic [7:0]  d;
      logic [15:0] f;
      int          gap;
      rw  = 1'($urandom_range(0, 1));
      idx = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      gap = $urandom_range(0, 2);
      f   = {rw, idx, 4'($urandom), d};
      send({f, 16'h0}, 16, gap);
      if (rw) begin
        mregs[idx] = d;
        exp_dout   = d;
        n_checks++;
        if (obs_wr[15] !== 1'b1 || obs_wr[14] !== 1'b0 || obs_idx[15] !== idx ||
            obs_dout[15] !== d || obs_oe[15] !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_write n=%0d got wr=%b idx=%0d dout=%h exp wr=1 idx=%0d dout=%h",
                   n, obs_wr[15], obs_idx[15], obs_dout[15], idx, d);
        end
      end else begin
        for (int k = 0; k < 16; k++) begin
          logic exp_oe, exp_sdo;
          exp_oe  = (k >= 8);
          exp_sdo = exp_oe ? mregs[idx][15-k] : 1'b0;
          n_checks++;
          if (obs_sdo[k] !== exp_sdo || obs_oe[k] !== exp_oe || obs_dout[k] !== exp_dout ||
              (k > 0 && obs_wr[k] !== 1'b0)) begin
            n_err++;
            $display("FAIL rnd_read n=%0d k=%0d got sdo=%b oe=%b dout=%h exp sdo=%b oe=%b dout=%h",
                     n, k, obs_sdo[k], obs_oe[k], obs_dout[k], exp_sdo, exp_oe, exp_dout);
          end
        end
      end
    end
    tick(1'b1, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_read_reserved();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
